// File: rtl/imem_loader.sv
// Program-memory loader: writes a streamed program into a DEPTH x WIDTH RAM and serves registered reads.
// Optional trailing checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [AW:0]      Length,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [AW-1:0]    Rd_Addr,
  output logic [WIDTH-1:0] Rd_Data,
  output logic [AW:0]      Wr_Count,
  output logic             Busy,
  output logic             Loaded,
  output logic             Error
);

  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t           state, state_next;
  logic [AW:0]      len, len_next;
  logic [AW:0]      count_next;
  logic             xfer;
  logic             wr_en;
  logic             last_word;
  logic [WIDTH-1:0] mem [DEPTH];

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] acc, acc_next;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      len      <= '0;
      Wr_Count <= '0;
    end else begin
      state    <= state_next;
      len      <= len_next;
      Wr_Count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    len_next   = len;
    count_next = Wr_Count;
    wr_en      = 1'b0;
    xfer       = In_Valid && In_Ready;
    last_word  = (Wr_Count == len - ONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_next   = acc;
`endif
    case (state)
      LOAD: begin
        if (xfer) begin
          wr_en      = 1'b1;
          count_next = Wr_Count + ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_next   = acc + In_Data;
          if (last_word) state_next = CHECK;
`else
          if (last_word) state_next = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      // The word after the last data word is the checksum; it is compared, never stored.
      CHECK: begin
        if (xfer) state_next = (In_Data == acc) ? DONE : ERR;
      end
`endif
      default: begin
        if (Start) begin
          len_next   = (Length == '0 || Length > FULL_LEN) ? FULL_LEN : Length;
          count_next = '0;
          state_next = LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_next   = '0;
`endif
        end
      end
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) acc <= '0;
    else         acc <= acc_next;
  end

  assign Busy  = (state == LOAD) || (state == CHECK);
  assign Error = (state == ERR);
`else
  assign Busy  = (state == LOAD);
  assign Error = 1'b0;
`endif

  assign In_Ready = Busy;
  assign Loaded   = (state == DONE);

  // RAM has no reset so it maps onto block memory; reads are read-first.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[Wr_Count[AW-1:0]] <= In_Data;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) Rd_Data <= '0;
    else         Rd_Data <= mem[Rd_Addr];
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-level reference model.
// Honours IMEM_LOADER_CHECKSUM_EN to exercise the checksum word.
module tb_imem_loader;
  localparam int WIDTH = 9;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             Clock = 1'b0;
  logic             Resetn = 1'b0;
  logic             Start = 1'b0;
  logic [AW:0]      Length = '0;
  logic [WIDTH-1:0] In_Data = '0;
  logic             In_Valid = 1'b0;
  logic             In_Ready;
  logic [AW-1:0]    Rd_Addr = '0;
  logic [WIDTH-1:0] Rd_Data;
  logic [AW:0]      Wr_Count;
  logic             Busy;
  logic             Loaded;
  logic             Error;

  imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Length(Length),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Wr_Count(Wr_Count),
    .Busy(Busy), .Loaded(Loaded), .Error(Error)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int passes = 0;

  // Reference model: program words, progress counters, completion flags.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_written [DEPTH];
  int               m_len = 0;
  int               m_count = 0;
  bit               m_busy = 0;
  bit               m_check = 0;
  bit               m_loaded = 0;
  bit               m_error = 0;
  logic [WIDTH-1:0] m_sum = '0;

  logic [WIDTH-1:0] stream [$];
  bit               pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input bit st, input int length, input logic [WIDTH-1:0] data,
                               input bit valid, input int raddr);
    logic [WIDTH-1:0] exp_rd;
    bit               rd_known;
    Start    = st;
    Length   = (AW+1)'(length);
    In_Data  = data;
    In_Valid = valid;
    Rd_Addr  = AW'(raddr);
    rd_known = m_written[raddr];
    exp_rd   = m_mem[raddr];
    if (st && !m_busy) begin
      m_len    = (length == 0 || length > DEPTH) ? DEPTH : length;
      m_count  = 0;
      m_busy   = 1;
      m_check  = 0;
      m_loaded = 0;
      m_error  = 0;
      m_sum    = '0;
    end else if (m_busy && valid) begin
      if (!m_check) begin
        m_mem[m_count]     = data;
        m_written[m_count] = 1;
        m_count++;
        m_sum += data;
        if (m_count == m_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          m_check = 1;
`else
          m_busy   = 0;
          m_loaded = 1;
`endif
        end
      end else begin
        m_busy  = 0;
        m_check = 0;
        if (data == m_sum) m_loaded = 1;
        else               m_error  = 1;
      end
    end
    @(posedge Clock);
    #1;
    checkOutput("in_ready", In_Ready, m_busy);
    checkOutput("busy", Busy, m_busy);
    checkOutput("loaded", Loaded, m_loaded);
    checkOutput("error", Error, m_error);
    checkOutput("wr_count", Wr_Count, m_count);
    if (rd_known) checkOutput("rd_data", Rd_Data, exp_rd);
    Start    = 1'b0;
    In_Valid = 1'b0;
  endtask

  task automatic applyReset();
    Resetn   = 1'b0;
    Start    = 1'b0;
    In_Valid = 1'b0;
    #2;
    m_busy   = 0;
    m_check  = 0;
    m_loaded = 0;
    m_error  = 0;
    m_count  = 0;
    checkOutput("rst_in_ready", In_Ready, 0);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_loaded", Loaded, 0);
    checkOutput("rst_error", Error, 0);
    checkOutput("rst_wr_count", Wr_Count, 0);
    checkOutput("rst_rd_data", Rd_Data, 0);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  task automatic startLoad(input int length);
    applyStimulus(1'b1, length, WIDTH'($urandom), 1'b0, $urandom_range(DEPTH-1));
  endtask

  task automatic appendChecksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] s;
    s = '0;
    foreach (stream[i]) s += stream[i];
    stream.push_back(s);
`endif
  endtask

  // Offers queued words while the model expects the loader to be busy; raddr < 0 picks random reads.
  task automatic offerStream(input int valid_pct, input int max_cycles, input int raddr);
    int  cyc;
    bit  v;
    bit  poke;
    cyc = 0;
    while (stream.size() > 0 && m_busy && cyc < max_cycles) begin
      v    = ($urandom_range(99) < valid_pct);
      poke = ($urandom_range(19) == 0);
      applyStimulus(poke, $urandom_range(63), v ? stream[0] : WIDTH'($urandom), v,
                    (raddr < 0) ? $urandom_range(DEPTH-1) : raddr);
      if (v) void'(stream.pop_front());
      cyc++;
    end
    checkOutput("load_budget", m_busy, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] old3, new3, w0, w1;
    int               n;

    applyReset();

    // Directed: four-word program with valid held high.
    stream.delete();
    stream = '{9'h1A0, 9'h00F, 9'h155, 9'h1FF};
    appendChecksum();
    startLoad(4);
    offerStream(100, 20, -1);
    checkOutput("t1_wr_count", Wr_Count, 4);
    applyStimulus(1'b0, 0, '0, 1'b0, 2);
    checkOutput("t1_rd2", Rd_Data, 9'h155);

    // Directed: gapped valid pattern.
    stream.delete();
    stream = '{9'h011, 9'h022, 9'h033};
    appendChecksum();
    startLoad(3);
    foreach (pat[i]) begin
      applyStimulus(1'b0, 0, pat[i] ? stream[0] : 9'h1EE, pat[i], i);
      if (pat[i]) void'(stream.pop_front());
    end
    offerStream(100, 20, -1);
    checkOutput("t2_loaded", Loaded, 1);
    checkOutput("t2_wr_count", Wr_Count, 3);

    // Directed: Length 0 means a full-depth load.
    stream.delete();
    for (int i = 0; i < DEPTH; i++) stream.push_back(WIDTH'(i));
    appendChecksum();
    startLoad(0);
    offerStream(100, 100, -1);
    applyStimulus(1'b0, 0, 9'h0AA, 1'b1, 31);
    checkOutput("t3_no_accept", Wr_Count, 32);
    checkOutput("t3_rd31", Rd_Data, 31);

    // Directed: reset in the middle of a load, then a clean reload.
    stream.delete();
    startLoad(5);
    applyStimulus(1'b0, 0, 9'h0F1, 1'b1, 0);
    applyStimulus(1'b0, 0, 9'h0F2, 1'b1, 1);
    applyReset();
    stream.delete();
    for (int i = 0; i < 5; i++) stream.push_back(WIDTH'($urandom));
    w0 = stream[0];
    w1 = stream[1];
    appendChecksum();
    startLoad(5);
    offerStream(100, 20, -1);
    applyStimulus(1'b0, 0, '0, 1'b0, 0);
    checkOutput("t4_rd0", Rd_Data, w0);
    applyStimulus(1'b0, 0, '0, 1'b0, 1);
    checkOutput("t4_rd1", Rd_Data, w1);

    // Directed: read-first behaviour on a same-address write.
    old3 = m_mem[3];
    new3 = old3 ^ 9'h1FF;
    stream.delete();
    stream = '{9'h005, 9'h006, 9'h007, new3};
    appendChecksum();
    startLoad(4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 0, stream[0], 1'b1, 3);
      void'(stream.pop_front());
    end
    applyStimulus(1'b0, 0, stream[0], 1'b1, 3);
    void'(stream.pop_front());
    checkOutput("t5_old", Rd_Data, old3);
    applyStimulus(1'b0, 0, (stream.size() > 0) ? stream[0] : 9'h000, stream.size() > 0, 3);
    checkOutput("t5_new", Rd_Data, new3);
    stream.delete();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Directed: checksum match and mismatch.
    stream = '{9'h100, 9'h150, 9'h050};
    startLoad(2);
    offerStream(100, 20, -1);
    checkOutput("t6_ok_loaded", Loaded, 1);
    checkOutput("t6_ok_error", Error, 0);
    stream = '{9'h100, 9'h150, 9'h051};
    startLoad(2);
    offerStream(100, 20, -1);
    checkOutput("t6_bad_error", Error, 1);
    checkOutput("t6_bad_loaded", Loaded, 0);
    startLoad(2);
    checkOutput("t6_start_clears", Error, 0);
    stream = '{9'h001, 9'h002, 9'h003};
    offerStream(100, 20, -1);
`endif

    // Randomized loads: random lengths, valid density, stray Start pulses.
    for (int it = 0; it < 10; it++) begin
      int length;
      length = $urandom_range(63);
      n = (length == 0 || length > DEPTH) ? DEPTH : length;
      stream.delete();
      for (int i = 0; i < n; i++) stream.push_back(WIDTH'($urandom));
      appendChecksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
      if ($urandom_range(3) == 0) stream[stream.size()-1] ^= 9'h001;
`endif
      startLoad(length);
      offerStream($urandom_range(100, 30), 400, -1);
      for (int k = 0; k < 3; k++)
        applyStimulus(1'b0, 0, WIDTH'($urandom), $urandom_range(1) == 1, $urandom_range(DEPTH-1));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
